// File: rtl/pipeline_fetch_queue.sv
// Stage-0 fetch with prefetch queue: MEMDATA->PipeOut in 1 clk (bypass) or 1 clk after reaching the head.
// Stall holds PipeOut while the queue keeps filling; fetch and PCRA strobes stop when full with no pop.

module syncFifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wrDat,
  output logic [WIDTH-1:0]           rdDat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !clr) mem[wrPtr] <= wrDat;
  end

  assign rdDat = mem[rdPtr];
  assign full  = (count == DepthCnt);
  assign empty = (count == '0);

  assert property (@(posedge clk) disable iff (rst || clr) !(push && full && !pop));
  assert property (@(posedge clk) disable iff (rst || clr) !(pop && empty));
  assert property (@(posedge clk) disable iff (rst) count <= DepthCnt);

endmodule

module pipeline_fetch_queue #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = '0
) (
  input  logic                       ClockIn,
  input  logic                       Reset,
  input  logic                       BusRequest,
  input  logic                       FetchSurpress,
  input  logic                       Stall,
  input  logic                       Flush,
  input  logic [DATA_WIDTH-1:0]      MEMDATA,
  input  logic                       Flags_5_PCRA_Flip,
  output logic [DATA_WIDTH-1:0]      PipeOut,
  output logic                       PipeValid,
  output logic                       Pipe0Out_0_IncPCRA0,
  output logic                       Pipe0Out_1_IncPCRA1,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Full,
  output logic                       Empty
);
  logic                  advance;
  logic                  popEn;
  logic                  fetchEn;
  logic                  bypassEn;
  logic                  pushEn;
  logic [DATA_WIDTH-1:0] headDat;
  logic [DATA_WIDTH-1:0] pipeNext;
  logic                  validNext;

  assign advance  = !Stall;
  assign popEn    = advance && !FetchSurpress && !Empty;
  // A full queue can still accept a byte when the head leaves in the same cycle.
  assign fetchEn  = !Reset && !BusRequest && !Flush && (!Full || popEn);
  assign bypassEn = advance && !FetchSurpress && Empty && fetchEn;
  assign pushEn   = fetchEn && !bypassEn;

  assign Pipe0Out_0_IncPCRA0 = fetchEn && !Flags_5_PCRA_Flip;
  assign Pipe0Out_1_IncPCRA1 = fetchEn &&  Flags_5_PCRA_Flip;

  syncFifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) queue (
    .clk   (ClockIn),
    .rst   (Reset),
    .clr   (Flush),
    .push  (pushEn),
    .pop   (popEn),
    .wrDat (MEMDATA),
    .rdDat (headDat),
    .count (Count),
    .full  (Full),
    .empty (Empty)
  );

  always_comb begin
    pipeNext  = PipeOut;
    validNext = PipeValid;
    if (Reset || Flush) begin
      pipeNext  = NOP_VALUE;
      validNext = 1'b0;
    end else if (advance) begin
      if (popEn) begin
        pipeNext  = headDat;
        validNext = 1'b1;
      end else if (bypassEn) begin
        pipeNext  = MEMDATA;
        validNext = 1'b1;
      end else begin
        pipeNext  = NOP_VALUE;
        validNext = 1'b0;
      end
    end
  end

  always_ff @(posedge ClockIn) begin
    PipeOut   <= pipeNext;
    PipeValid <= validNext;
  end

endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Directed table of per-cycle inputs with expected strobes (pre-edge) and registered outputs (post-edge).

module tb_pipeline_fetch_queue;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       BusRequest = 1'b0;
  logic       FetchSurpress = 1'b0;
  logic       Stall = 1'b0;
  logic       Flush = 1'b0;
  logic [7:0] MEMDATA = 8'h00;
  logic       Flip = 1'b0;
  logic [7:0] PipeOut;
  logic       PipeValid;
  logic       inc0;
  logic       inc1;
  logic [2:0] Count;
  logic       Full;
  logic       Empty;

  always #5 clk = ~clk;

  pipeline_fetch_queue #(
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH),
    .NOP_VALUE  (8'h00)
  ) dut (
    .ClockIn             (clk),
    .Reset               (Reset),
    .BusRequest          (BusRequest),
    .FetchSurpress       (FetchSurpress),
    .Stall               (Stall),
    .Flush               (Flush),
    .MEMDATA             (MEMDATA),
    .Flags_5_PCRA_Flip   (Flip),
    .PipeOut             (PipeOut),
    .PipeValid           (PipeValid),
    .Pipe0Out_0_IncPCRA0 (inc0),
    .Pipe0Out_1_IncPCRA1 (inc1),
    .Count               (Count),
    .Full                (Full),
    .Empty               (Empty)
  );

  typedef struct {
    int rst, stall, fs, br, fl, flip, mem;
    int inc0, inc1, out, vld, cnt;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   vecIdx = 0;

  function automatic vec_t mk(input int rst, input int stall, input int fs, input int br,
                              input int fl, input int flip, input int mem, input int i0,
                              input int i1, input int out, input int vld, input int cnt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.fs = fs; v.br = br; v.fl = fl; v.flip = flip;
    v.mem = mem; v.inc0 = i0; v.inc1 = i1; v.out = out; v.vld = vld; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic runVec(input vec_t v);
    @(negedge clk);
    Reset         = v.rst[0];
    Stall         = v.stall[0];
    FetchSurpress = v.fs[0];
    BusRequest    = v.br[0];
    Flush         = v.fl[0];
    Flip          = v.flip[0];
    MEMDATA       = v.mem[7:0];
    #1;
    check("inc0", vecIdx, int'(inc0), v.inc0);
    check("inc1", vecIdx, int'(inc1), v.inc1);
    @(posedge clk);
    #1;
    check("pipeOut", vecIdx, int'(PipeOut), v.out);
    check("pipeValid", vecIdx, int'(PipeValid), v.vld);
    check("count", vecIdx, int'(Count), v.cnt);
    check("full", vecIdx, int'(Full), (v.cnt == DEPTH) ? 1 : 0);
    check("empty", vecIdx, int'(Empty), (v.cnt == 0) ? 1 : 0);
    vecIdx++;
  endtask

  task automatic step(input int rst, input int stall, input int fs, input int br,
                      input int fl, input int flip, input int mem, input int i0,
                      input int i1, input int out, input int vld, input int cnt);
    runVec(mk(rst, stall, fs, br, fl, flip, mem, i0, i1, out, vld, cnt));
  endtask

  initial begin
    //          rst stl fs br fl flp mem     i0 i1 out    v cnt
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 'hAA,  0, 0, 'h00, 0, 0));
    // free run, bypass path
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h10,  1, 0, 'h10, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h11,  1, 0, 'h11, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h12,  1, 0, 'h12, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h13,  1, 0, 'h13, 1, 0));
    // stall fills the queue, then fetch stops at full
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 'h20,  1, 0, 'h13, 1, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 'h21,  1, 0, 'h13, 1, 2));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 'h22,  1, 0, 'h13, 1, 3));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 'h23,  1, 0, 'h13, 1, 4));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 'h24,  0, 0, 'h13, 1, 4));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 'h25,  0, 0, 'h13, 1, 4));
    // release: pop and push together while full
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h26,  1, 0, 'h20, 1, 4));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h99,  0, 0, 'h21, 1, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h99,  0, 0, 'h22, 1, 2));
    // FetchSurpress with Count=2: NOPs issued, queue keeps filling
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 'h30,  1, 0, 'h00, 0, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 'h31,  1, 0, 'h00, 0, 4));
    // drain under BusRequest: nothing lost, order kept
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h98,  0, 0, 'h23, 1, 3));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h98,  0, 0, 'h26, 1, 2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h98,  0, 0, 'h30, 1, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h98,  0, 0, 'h31, 1, 0));
    // BusRequest while empty: bubbles
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h97,  0, 0, 'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h97,  0, 0, 'h00, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 'h97,  0, 0, 'h00, 0, 0));
    // PCRA half selection follows Flip in the same cycle
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h40,  0, 1, 'h40, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h41,  0, 1, 'h41, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 'h42,  1, 0, 'h42, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 'h43,  0, 1, 'h43, 1, 0));

    foreach (vecs[i]) runVec(vecs[i]);

    // Flush with three queued bytes and Stall held
    step(0, 1, 0, 0, 0, 0, 'h50,  1, 0, 'h43, 1, 1);
    step(0, 1, 0, 0, 0, 0, 'h51,  1, 0, 'h43, 1, 2);
    step(0, 1, 0, 0, 0, 0, 'h52,  1, 0, 'h43, 1, 3);
    step(0, 1, 0, 0, 1, 1, 'h53,  0, 0, 'h00, 0, 0);
    step(0, 0, 0, 0, 0, 0, 'h54,  1, 0, 'h54, 1, 0);
    // Reset mid-fill gives the same cleared state
    step(0, 1, 0, 0, 0, 0, 'h60,  1, 0, 'h54, 1, 1);
    step(0, 1, 0, 0, 0, 0, 'h61,  1, 0, 'h54, 1, 2);
    step(1, 1, 0, 0, 0, 0, 'h62,  0, 0, 'h00, 0, 0);
    step(0, 0, 0, 0, 0, 0, 'h63,  1, 0, 'h63, 1, 0);
    // Flush beats BusRequest and FetchSurpress; queue empty afterwards
    step(0, 1, 0, 0, 0, 0, 'h70,  1, 0, 'h63, 1, 1);
    step(0, 0, 1, 1, 1, 0, 'h71,  0, 0, 'h00, 0, 0);
    step(0, 0, 0, 0, 0, 0, 'h72,  1, 0, 'h72, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
